fp_div_special_encoder: RTL
===========================

// Module: fp_div_special_encoder
// PURPOSE
// - Output end of the single-precision divider. Classifies operands A and B
//   (zero / inf / NaN / finite) and packs the final IEEE-754 word.
// - Emits an encoded special value (inf, NaN, signed zero) when one applies;
//   otherwise packs the divider's raw quotient, saturating to inf or flushing to zero.
// - 2-stage valid/ready pipeline between the quotient datapath and the result port.
// PARAMETERS
// - EXP_W      10             width of signed biased quotient exponent q_exp
// - CANON_NAN  32'h7FC00000   word emitted for every NaN result
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      async active-low reset
// - in_valid   in   1      a_word/b_word/q_exp/q_mant valid
// - in_ready   out  1      stage 1 can accept this cycle
// - a_word     in   32     dividend, IEEE-754 single
// - b_word     in   32     divisor, IEEE-754 single
// - q_exp      in   EXP_W  signed biased exponent of normalised quotient
// - q_mant     in   23     normalised quotient fraction, hidden bit dropped
// - out_valid  out  1      out_result valid
// - out_ready  in   1      downstream accepts
// - out_result out  32     packed IEEE-754 quotient
// - out_class  out  2      00 normal, 01 zero, 10 inf, 11 NaN
// BEHAVIOUR
// - Reset: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_class=00.
//   in_ready=1 once reset is released. Reset mid-operation drops all in-flight data.
// - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
// - Pipeline:
//   - s2_adv = !s2_valid | out_ready.
//   - s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no bubble).
//   - Latency 2 cycles, throughput 1/cycle.
//   - Under backpressure both stages hold contents; out_result stays stable while out_valid=1.
// - Stage 1 registers sign = a[31]^b[31], q_exp, q_mant and per-operand class:
//   - exp==8'hFF & frac==0 -> inf; exp==8'hFF & frac!=0 -> NaN.
//   - exp==0 -> zero (denormals flushed, any fraction).
//   - otherwise finite.
// - Stage 2 selects the result, first match wins:
//   1. A NaN or B NaN -> CANON_NAN, class 11.
//   2. inf/inf or zero/zero -> CANON_NAN, class 11 (invalid).
//   3. A inf (B finite or zero) -> {sign,8'hFF,23'h0}, class 10.
//   4. B inf (A finite or zero) -> {sign,31'h0}, class 01.
//   5. B zero (A finite) -> {sign,8'hFF,23'h0}, class 10 (div-by-zero).
//   6. A zero (B finite) -> {sign,31'h0}, class 01.
//   7. q_exp >= 255 (signed) -> signed inf, class 10 (overflow).
//   8. q_exp <= 0 (signed) -> signed zero, class 01 (underflow flush).
//   9. else {sign,q_exp[7:0],q_mant}, class 00.
// - q_exp and q_mant are ignored in cases 1-6.
// - q_exp is compared as signed EXP_W; no wrap-around.
// - Simultaneous in/out transfer with both stages full is legal; nothing is lost.
// CONFIGURATION
// - FP_DIV_EXCFLAGS_EN defined:
//   - Adds ports flags_clr (in, 1) and exc_flags (out, 5) = {invalid,divzero,overflow,underflow,nan_in}.
//   - Sticky bits set when a stage-2 result transfers out under cases 2,5,7,8,1 respectively.
//   - flags_clr clears them synchronously; a set in the same cycle wins over clear.
//   - exc_flags reset value is 0.
// - FP_DIV_EXCFLAGS_EN undefined: flags ports and registers absent; datapath identical.
// TESTING
// - a=3F800000 b=40000000 q_exp=126 q_mant=0, out_ready=1
//   -> out_result=3F000000, class 00, two cycles after accept.
// - a=BF800000 b=00000000 -> FF800000, class 10; divzero flag set (flags build).
// - a=7F800000 b=7F800000 -> 7FC00000, class 11; a=00000000 b=80000000 -> 7FC00000.
// - a=7FA00001 b=3F800000 -> 7FC00000; a=3F800000 b=FF800000 -> 80000000.
// - Finite operands, q_exp=300 -> 7F800000 class 10; q_exp=-5 -> 00000000 class 01.
// - Stream 4 items, hold out_ready=0 for 3 cycles:
//   - in_ready drops after 2 accepts; out_result stable.
//   - Release -> all 4 results in order.
//   - Assert rst_n=0 mid-stream -> out_valid=0 at once.

Source files
------------

// File: rtl/fp_div_special_encoder.sv
// Output stage of the single-precision divider: classifies operands, applies IEEE-754 special cases,
// and packs the quotient through a 2-stage valid/ready pipeline. Optional sticky flags: FP_DIV_EXCFLAGS_EN.
module fp_div_special_encoder #(
  parameter int unsigned EXP_W     = 10,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_word,
  input  logic [31:0]      b_word,
  input  logic [EXP_W-1:0] q_exp,
  input  logic [22:0]      q_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [1:0]       out_class
`ifdef FP_DIV_EXCFLAGS_EN
  ,
  input  logic             flags_clr,
  output logic [4:0]       exc_flags
`endif
);

  localparam logic [1:0] CL_FIN  = 2'b00;
  localparam logic [1:0] CL_ZERO = 2'b01;
  localparam logic [1:0] CL_INF  = 2'b10;
  localparam logic [1:0] CL_NAN  = 2'b11;

  localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_UNF = '0;

  function automatic logic [1:0] classify(input logic [31:0] w);
    if (w[30:23] == 8'hFF) return (w[22:0] == 23'd0) ? CL_INF : CL_NAN;
    if (w[30:23] == 8'h00) return CL_ZERO;
    return CL_FIN;
  endfunction

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [EXP_W-1:0] r_s1_exp;
  logic [22:0]      r_s1_mant;
  logic [1:0]       r_s1_a_cls;
  logic [1:0]       r_s1_b_cls;
  logic             r_s2_valid;
  logic [31:0]      r_s2_result;
  logic [1:0]       r_s2_class;

  logic        w_s1_adv;
  logic        w_s2_adv;
  logic [31:0] w_result;
  logic [1:0]  w_class;
  logic [31:0] w_inf;
  logic [31:0] w_zero;
`ifdef FP_DIV_EXCFLAGS_EN
  logic [4:0]  w_exc;
  logic [4:0]  r_s2_exc;
  logic [4:0]  r_flags;
`endif

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_class  = r_s2_class;
  assign w_inf      = {r_s1_sign, 8'hFF, 23'h0};
  assign w_zero     = {r_s1_sign, 31'h0};

  // Stage 1: capture sign, raw quotient and operand classes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_a_cls <= CL_FIN;
      r_s1_b_cls <= CL_FIN;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= a_word[31] ^ b_word[31];
        r_s1_exp   <= q_exp;
        r_s1_mant  <= q_mant;
        r_s1_a_cls <= classify(a_word);
        r_s1_b_cls <= classify(b_word);
      end
    end
  end

  // Result selection, first matching rule wins
  always_comb begin
    w_result = {r_s1_sign, r_s1_exp[7:0], r_s1_mant};
    w_class  = 2'b00;
`ifdef FP_DIV_EXCFLAGS_EN
    w_exc    = 5'b00000;
`endif
    if (r_s1_a_cls == CL_NAN || r_s1_b_cls == CL_NAN) begin
      w_result = CANON_NAN;
      w_class  = 2'b11;
`ifdef FP_DIV_EXCFLAGS_EN
      w_exc    = 5'b00001;
`endif
    end else if ((r_s1_a_cls == CL_INF && r_s1_b_cls == CL_INF) ||
                 (r_s1_a_cls == CL_ZERO && r_s1_b_cls == CL_ZERO)) begin
      w_result = CANON_NAN;
      w_class  = 2'b11;
`ifdef FP_DIV_EXCFLAGS_EN
      w_exc    = 5'b10000;
`endif
    end else if (r_s1_a_cls == CL_INF) begin
      w_result = w_inf;
      w_class  = 2'b10;
    end else if (r_s1_b_cls == CL_INF) begin
      w_result = w_zero;
      w_class  = 2'b01;
    end else if (r_s1_b_cls == CL_ZERO) begin
      w_result = w_inf;
      w_class  = 2'b10;
`ifdef FP_DIV_EXCFLAGS_EN
      w_exc    = 5'b01000;
`endif
    end else if (r_s1_a_cls == CL_ZERO) begin
      w_result = w_zero;
      w_class  = 2'b01;
    end else if ($signed(r_s1_exp) >= EXP_OVF) begin
      w_result = w_inf;
      w_class  = 2'b10;
`ifdef FP_DIV_EXCFLAGS_EN
      w_exc    = 5'b00100;
`endif
    end else if ($signed(r_s1_exp) <= EXP_UNF) begin
      w_result = w_zero;
      w_class  = 2'b01;
`ifdef FP_DIV_EXCFLAGS_EN
      w_exc    = 5'b00010;
`endif
    end
  end

  // Stage 2: holds the packed word stable while backpressured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_class  <= 2'b00;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_class  <= w_class;
      end
    end
  end

`ifdef FP_DIV_EXCFLAGS_EN
  // Sticky flags set on output transfer; a set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_exc <= '0;
      r_flags  <= '0;
    end else begin
      if (w_s2_adv && r_s1_valid) r_s2_exc <= w_exc;
      r_flags <= (flags_clr ? 5'b00000 : r_flags) |
                 ((r_s2_valid && out_ready) ? r_s2_exc : 5'b00000);
    end
  end

  assign exc_flags = r_flags;
`endif

endmodule
